// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/writeback and drives
// every datapath enable and mux select. Outputs are registered alongside the state.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
  } ctrl_t;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  // Low for the first cycle after reset so the first released edge lands in FETCH.
  logic   live_q;
  logic   funct_ok;
  logic   op_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b000;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    op_ok = 1'b1;
    case (op)
      OpLw, OpSw, OpBeq, OpAddi, OpJ: op_ok = 1'b1;
      OpRtype:                        op_ok = funct_ok;
      default:                        op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (!op_ok) begin
          state_d = StFetch;
        end else begin
          case (op)
            OpLw, OpSw: state_d = StMemAdr;
            OpRtype:    state_d = StRtypeEx;
            OpBeq:      state_d = StBeqEx;
            OpAddi:     state_d = StAddiEx;
            OpJ:        state_d = StJEx;
            default:    state_d = StFetch;
          endcase
        end
      end
      StMemAdr:  state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
    if (!live_q) begin
      state_d = StFetch;
    end
  end

  // Outputs for the state being entered, so they are valid throughout that state.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      StFetch: begin
        ctrl_d.ir_write    = 1'b1;
        ctrl_d.alu_src_b   = 2'b01;
        ctrl_d.alu_control = 3'b010;
        ctrl_d.pc_write    = 1'b1;
      end
      StDecode: begin
        ctrl_d.alu_src_b   = 2'b11;
        ctrl_d.alu_control = 3'b010;
      end
      StMemAdr, StAddiEx: begin
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_src_b   = 2'b10;
        ctrl_d.alu_control = 3'b010;
      end
      StMemRd: ctrl_d.iord = 1'b1;
      StMemWb: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl_d.iord       = 1'b1;
        ctrl_d.mem_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      StRtypeEx: begin
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_control = funct_alu;
      end
      StRtypeWb: begin
        ctrl_d.reg_dst     = 1'b1;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.instr_done  = 1'b1;
        ctrl_d.alu_control = ctrl_q.alu_control;
      end
      StBeqEx: begin
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_control = 3'b110;
        ctrl_d.pc_src      = 2'b01;
        ctrl_d.branch      = 1'b1;
        ctrl_d.instr_done  = 1'b1;
      end
      StAddiWb: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      StJEx: begin
        ctrl_d.pc_src     = 2'b10;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      ctrl_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      live_q  <= 1'b1;
    end
  end

  assign iord        = ctrl_q.iord;
  assign mem_write   = ctrl_q.mem_write;
  assign ir_write    = ctrl_q.ir_write;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_control = ctrl_q.alu_control;
  assign pc_src      = ctrl_q.pc_src;
  assign pc_en       = ctrl_q.pc_write | (ctrl_q.branch & zero);
  assign instr_done  = ctrl_q.instr_done;
  assign illegal     = !rst && live_q && (state_q == StDecode) && !op_ok;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: expected per-cycle outputs are queued per
// instruction from a reference table and compared each cycle on the falling edge.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'h3f;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b1;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       pc_en, instr_done, illegal;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en, instr_done, illegal;
  } obs_t;

  obs_t sb[$];

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o = '{state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
          alu_src_b, alu_control, pc_src, pc_en, instr_done, illegal};
    return o;
  endfunction

  function automatic logic [2:0] ref_funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic ref_funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Expected outputs in state s; s < 0 means "held in reset".
  function automatic obs_t model(input int s, input logic [2:0] ralu, input logic z,
                                 input logic ill);
    obs_t o;
    o = '0;
    if (s < 0) return o;
    o.st = s[3:0];
    case (s)
      0:  begin o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_control = 3'b010; o.pc_en = 1; end
      1:  begin o.alu_src_b = 2'b11; o.alu_control = 3'b010; o.illegal = ill; end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
      3:  o.iord = 1;
      4:  begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
      5:  begin o.iord = 1; o.mem_write = 1; o.instr_done = 1; end
      6:  begin o.alu_src_a = 1; o.alu_control = ralu; end
      7:  begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; o.alu_control = ralu; end
      8:  begin
        o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.pc_en = z;
        o.instr_done = 1;
      end
      9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
      10: begin o.reg_write = 1; o.instr_done = 1; end
      11: begin o.pc_src = 2'b10; o.pc_en = 1; o.instr_done = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Queue the first lim cycles of one instruction; n returns how many were queued.
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int lim, output int n);
    int   seq[$];
    logic ill;
    ill = 1'b0;
    case (o)
      6'b100011: seq = {0, 1, 2, 3, 4};
      6'b101011: seq = {0, 1, 2, 5};
      6'b000000: begin
        if (ref_funct_ok(f)) seq = {0, 1, 6, 7};
        else begin seq = {0, 1}; ill = 1'b1; end
      end
      6'b000100: seq = {0, 1, 8};
      6'b001000: seq = {0, 1, 9, 10};
      6'b000010: seq = {0, 1, 11};
      default:   begin seq = {0, 1}; ill = 1'b1; end
    endcase
    n = 0;
    foreach (seq[i]) begin
      if (n < lim) begin
        sb.push_back(model(seq[i], ref_funct_alu(f), z, (seq[i] == 1) && ill));
        n++;
      end
    end
  endtask

  task automatic test_reset();
    obs_t e, g;
    rst = 1'b1; zero = 1'b1; op = 6'h3f;
    repeat (2) @(posedge clk);
    sb.push_back(model(-1, 3'b000, 1'b0, 1'b0));
    @(negedge clk);
    e = sb.pop_front(); g = observe(); n_tests++;
    if (g !== e) begin
      n_fail++; $display("FAIL reset: got %h exp %h", g, e);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    obs_t e, g;
    int   n;
    op = 6'b100011; funct = 6'h00; zero = 1'b1;
    push_instr(op, funct, zero, 99, n);
    repeat (n) begin
      @(negedge clk);
      e = sb.pop_front(); g = observe(); n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL lw st=%0d: got %h exp %h", state, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    obs_t       e, g;
    int         n;
    logic [5:0] ops[4];
    logic [5:0] fns[4];
    ops = '{6'b101011, 6'b000000, 6'b000000, 6'b001000};
    fns = '{6'b000000, 6'b100010, 6'b101010, 6'b100101};
    zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = ops[k]; funct = fns[k];
      push_instr(op, funct, zero, 99, n);
      repeat (n) begin
        @(negedge clk);
        e = sb.pop_front(); g = observe(); n_tests++;
        if (g !== e) begin
          n_fail++; $display("FAIL b2b[%0d] st=%0d: got %h exp %h", k, state, g, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_beq();
    obs_t e, g;
    int   n;
    op = 6'b000100; funct = 6'b100100;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      push_instr(op, funct, zero, 99, n);
      repeat (n) begin
        @(negedge clk);
        e = sb.pop_front(); g = observe(); n_tests++;
        if (g !== e) begin
          n_fail++; $display("FAIL beq z=%0b st=%0d: got %h exp %h", zero, state, g, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jump_illegal();
    obs_t       e, g;
    int         n;
    logic [5:0] ops[3];
    logic [5:0] fns[3];
    ops = '{6'b000010, 6'b111111, 6'b000000};
    fns = '{6'b000000, 6'b100000, 6'b000111};
    zero = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op = ops[k]; funct = fns[k];
      push_instr(op, funct, zero, 99, n);
      repeat (n) begin
        @(negedge clk);
        e = sb.pop_front(); g = observe(); n_tests++;
        if (g !== e) begin
          n_fail++; $display("FAIL j/illegal[%0d] st=%0d: got %h exp %h", k, state, g, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // sw up to MEMWR, hold reset for 3 cycles, then a full j after release.
  task automatic test_reset_hold();
    obs_t e, g;
    int   n;
    op = 6'b101011; funct = 6'h00; zero = 1'b1;
    push_instr(op, funct, zero, 4, n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = sb.pop_front(); g = observe(); n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL rsthold sw st=%0d: got %h exp %h", state, g, e);
      end
      if (c == n - 1) rst = 1'b1;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      sb.push_back(model(-1, 3'b000, 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front(); g = observe(); n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL rsthold cyc%0d: got %h exp %h", c, g, e);
      end
      if (c == 2) rst = 1'b0;
      @(posedge clk); #1;
    end
    op = 6'b000010;
    push_instr(op, funct, zero, 99, n);
    repeat (n) begin
      @(negedge clk);
      e = sb.pop_front(); g = observe(); n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL rsthold post st=%0d: got %h exp %h", state, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  // lw aborted while in MEMRD: next state is FETCH with no writeback.
  task automatic test_reset_mid();
    obs_t e, g;
    int   n;
    op = 6'b100011; funct = 6'h00; zero = 1'b0;
    push_instr(op, funct, zero, 4, n);
    sb.push_back(model(-1, 3'b000, 1'b0, 1'b0));
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      e = sb.pop_front(); g = observe(); n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL rstmid cyc%0d st=%0d: got %h exp %h", c, state, g, e);
      end
      if (c == n - 1) rst = 1'b1;
      if (c == n) rst = 1'b0;
      @(posedge clk); #1;
    end
    op = 6'b001000;
    push_instr(op, funct, zero, 99, n);
    repeat (n) begin
      @(negedge clk);
      e = sb.pop_front(); g = observe(); n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL rstmid post st=%0d: got %h exp %h", state, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_beq();
    test_jump_illegal();
    test_reset_hold();
    test_reset_mid();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard: got %0d leftover entries exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the MIPS32 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. It is the producer of the 3-bit ALU control code and the consumer of the ALU `zero` flag. It replaces single-cycle decode, so that one ALU and one memory port can be shared across the cycles of an instruction.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `op`  in  6  opcode, IR[31:26], from the instruction register
- `funct`  in  6  function field, IR[5:0]
- `zero`  in  1  ALU zero flag; valid in the BEQEX cycle
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write enable
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `alu_control`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `pc_en`  out  1  PC load enable (see Operation)
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction
- `illegal`  out  1  one-cycle pulse in DECODE when the op/funct pair is unsupported
- `state`  out  4  current state encoding, for debug

## Operation
- The state register is 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable; if entered, go to FETCH.
- Outputs are a Moore decode of `state`. The only exception is `pc_en = pc_write | (branch & zero)`.
- Any output not listed for a state is 0 in that state.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (precomputes the branch target). Next state by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - any other op → FETCH, with `illegal`=1
- MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state is MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next state is FETCH.
- MEMWR: iord=1, mem_write=1, instr_done=1. Next state is FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00. alu_control comes from `funct`:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - Next state is RTYPEWB.
- RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. alu_control is held at the same decoded value. Next state is FETCH.
- Unsupported R-type `funct`: detected in DECODE. Raise `illegal`, go to FETCH, no register write.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, branch=1, instr_done=1. Next state is FETCH.
  - alu_control must be 110 here, because the ALU updates `zero` only on sub.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010. Next state is ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next state is FETCH.
- JEX: pc_src=10, pc_write=1, instr_done=1. Next state is FETCH.

## Timing
- Reset:
  - While `rst`=1, every output is forced to 0 (including `alu_control`=000 and `state`=0), and the next state is FETCH.
  - On the first edge with `rst`=0, the block is in FETCH with fetch outputs active.
  - `rst` asserted in any state aborts the instruction at the next edge. No partial writeback occurs after that edge.
- Cycles per instruction, FETCH through done state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `zero` is sampled combinationally in BEQEX only. In all other states `pc_en` equals `pc_write`, regardless of `zero`.
- `instr_done` and `illegal` are never high in the same cycle. Each is exactly one cycle wide.

## Test plan
- Reset hold: rst=1 for 3 cycles from state 5 → all outputs 0; after release, state=0, ir_write=1, pc_en=1, alu_control=010.
- lw (op=100011) → state sequence 0,1,2,3,4. In state 4: reg_write=1, mem_to_reg=1, instr_done=1.
- sw, then R-type (funct 100010, 101010), then addi, back-to-back → state 5 has mem_write=1. alu_control=110 and then 111 in states 6/7. State 10 has reg_write=1 and reg_dst=0.
- beq with zero=1, then beq with zero=0 → in state 8 both times: alu_control=110 and pc_src=01; pc_en=1 and then 0. Both take 3 cycles.
- j (op=000010) → state 11 with pc_src=10 and pc_en=1; op=111111 → `illegal` pulses in DECODE, returns to FETCH, reg_write and mem_write never asserted.
- Reset mid-instruction: rst=1 during state 3 (lw) → next state 0; reg_write stays 0 throughout.
